// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Round-robin grant in IDLE, one EXEC cycle to capture the ALU result,
// then a held response tagged with the requester ID. Illegal opcodes
// bypass EXEC and respond with an error.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,

    output logic [WIDTH-1:0] alu_da,
    output logic [WIDTH-1:0] alu_db,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_dc,
    input  logic             alu_zero,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             rsp_err
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t           state;
    logic             prio;

    logic             grant_id;
    logic             accept;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [2:0]       sel_op;
    logic             sel_legal;

    // Round-robin grant, request mux and combinational ready generation
    always_comb begin
        grant_id = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = prio;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end

        accept     = rst_n && (state == IDLE) && (req0_valid || req1_valid);
        req0_ready = accept && !grant_id;
        req1_ready = accept && grant_id;

        sel_a  = grant_id ? req1_a  : req0_a;
        sel_b  = grant_id ? req1_b  : req0_b;
        sel_op = grant_id ? req1_op : req0_op;
    end

    // Opcode legality: add, sub, and, or, xor are the only ALU functions
    always_comb begin
        case (sel_op)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: sel_legal = 1'b1;
            default:                                sel_legal = 1'b0;
        endcase
    end

    // Control FSM; operand and response registers double as the outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            prio      <= 1'b0;
            alu_da    <= '0;
            alu_db    <= '0;
            alu_op    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_zero  <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_da <= sel_a;
                        alu_db <= sel_b;
                        alu_op <= sel_op;
                        // rsp_id is safe to update here: rsp_valid is low in IDLE
                        rsp_id <= grant_id;
                        if (sel_legal) begin
                            state <= EXEC;
                        end else begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                            rsp_zero  <= 1'b0;
                        end
                    end
                end
                EXEC: begin
                    rsp_data  <= alu_dc;
                    rsp_zero  <= alu_zero;
                    rsp_err   <= 1'b0;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        prio      <= ~rsp_id;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
